// File: rtl/maxigp_arb_pkg.sv
// Shared types and constants for the MAXIGP register-bus arbiter.
//   state_e      : transaction FSM states (IDLE, BUS, RESP)
//   RESP_OKAY    : AXI OKAY response code
//   RESP_SLVERR  : AXI SLVERR response code (register bus timeout)
package maxigp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/maxigp_rr_arbiter.sv
// Combinational round-robin grant for NPORT requesters.
//   pending   in   NPORT   per-port request
//   ptr       in   PTR_W   highest-priority port index
//   grant     out  NPORT   one-hot grant (all zero when nothing pending)
//   grant_idx out  PTR_W   index of the granted port
//   any       out  1       at least one port pending
module maxigp_rr_arbiter #(
    parameter int NPORT = 2,
    parameter int PTR_W = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic [NPORT-1:0] pending,
    input  logic [PTR_W-1:0] ptr,
    output logic [NPORT-1:0] grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any
);

    logic [PTR_W-1:0] idx;

    // Walk the ports starting at ptr, wrapping at NPORT; first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int i = 0; i < NPORT; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NPORT);
            if (!any && pending[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/maxigp_reg_arbiter.sv
// Shares one PL req/ack register bus between NPORT single-beat AXI slave
// ports. Requests are arbitrated round-robin, one transaction in flight in
// total; B/R responses return on the originating port with the original ID.
//
// Optional build macro: MAXIGP_ARB_TIMEOUT_EN
//   defined   : BUS gives up after TIMEOUT cycles without reg_ack and answers
//               SLVERR with zero read data.
//   undefined : BUS waits for reg_ack forever; responses are always OKAY.
//
// Ports (port p of each packed array belongs to AXI port p):
//   aclk, areset              clock, async active-high reset
//   s_aw*/s_w*/s_b*           AXI write address/data/response channels
//   s_ar*/s_r*                AXI read address/data channels
//   reg_req/we/addr/wdata/wstrb  register bus request, held until reg_ack
//   reg_ack/reg_rdata         register bus completion and read data
module maxigp_reg_arbiter
    import maxigp_arb_pkg::*;
#(
    parameter int NPORT   = 2,
    parameter int ADDR_W  = 40,
    parameter int DATA_W  = 32,
`ifdef MAXIGP_ARB_TIMEOUT_EN
    parameter int TIMEOUT = 255,
`endif
    parameter int ID_W    = 16
) (
    input  logic                              aclk,
    input  logic                              areset,

    input  logic [NPORT-1:0]                  s_awvalid,
    output logic [NPORT-1:0]                  s_awready,
    input  logic [NPORT-1:0][ID_W-1:0]        s_awid,
    input  logic [NPORT-1:0][ADDR_W-1:0]      s_awaddr,
    input  logic [NPORT-1:0]                  s_wvalid,
    output logic [NPORT-1:0]                  s_wready,
    input  logic [NPORT-1:0][DATA_W-1:0]      s_wdata,
    input  logic [NPORT-1:0][DATA_W/8-1:0]    s_wstrb,
    output logic [NPORT-1:0]                  s_bvalid,
    input  logic [NPORT-1:0]                  s_bready,
    output logic [NPORT-1:0][ID_W-1:0]        s_bid,
    output logic [NPORT-1:0][1:0]             s_bresp,

    input  logic [NPORT-1:0]                  s_arvalid,
    output logic [NPORT-1:0]                  s_arready,
    input  logic [NPORT-1:0][ID_W-1:0]        s_arid,
    input  logic [NPORT-1:0][ADDR_W-1:0]      s_araddr,
    output logic [NPORT-1:0]                  s_rvalid,
    input  logic [NPORT-1:0]                  s_rready,
    output logic [NPORT-1:0][ID_W-1:0]        s_rid,
    output logic [NPORT-1:0][DATA_W-1:0]      s_rdata,
    output logic [NPORT-1:0][1:0]             s_rresp,

    output logic                              reg_req,
    output logic                              reg_we,
    output logic [ADDR_W-1:0]                 reg_addr,
    output logic [DATA_W-1:0]                 reg_wdata,
    output logic [DATA_W/8-1:0]               reg_wstrb,
    input  logic                              reg_ack,
    input  logic [DATA_W-1:0]                 reg_rdata
);

    localparam int PTR_W  = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int STRB_W = DATA_W / 8;

    state_e             state, state_nx;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   sel_idx;
    logic [NPORT-1:0]   wr_pend, pending, grant;
    logic               any, sel_we, accept, resp_hs, tmo_hit;

    logic               cap_we;
    logic [ID_W-1:0]    cap_id;
    logic [ADDR_W-1:0]  cap_addr;
    logic [DATA_W-1:0]  cap_wdata;
    logic [STRB_W-1:0]  cap_wstrb;
    logic [DATA_W-1:0]  cap_rdata;
    logic [1:0]         cap_resp;

    // A write needs both AW and W; a lone AW is not a request yet.
    assign wr_pend = s_awvalid & s_wvalid;
    assign pending = wr_pend | s_arvalid;

    maxigp_rr_arbiter #(.NPORT(NPORT), .PTR_W(PTR_W)) u_rr (
        .pending   (pending),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (sel_idx),
        .any       (any)
    );

    // Write takes precedence over read on the same port.
    assign sel_we  = wr_pend[sel_idx];
    assign accept  = (state == IDLE) && any;
    assign resp_hs = (state == RESP) &&
                     (cap_we ? s_bready[gnt_idx] : s_rready[gnt_idx]);

`ifdef MAXIGP_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Counts BUS cycles; fires on the TIMEOUT-th one unless ack arrives.
    assign tmo_hit = (state == BUS) && !reg_ack && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)              tmo_cnt <= '0;
        else if (state != BUS)   tmo_cnt <= '0;
        else                     tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        s_awready = '0;
        s_wready  = '0;
        s_arready = '0;
        unique case (state)
            IDLE: begin
                if (any) begin
                    state_nx = BUS;
                    // Ready is a single-cycle pulse: the handshake completes
                    // this cycle and the FSM leaves IDLE on the same edge.
                    if (sel_we) begin
                        s_awready = grant;
                        s_wready  = grant;
                    end else begin
                        s_arready = grant;
                    end
                end
            end
            BUS:     if (reg_ack || tmo_hit) state_nx = RESP;
            RESP:    if (resp_hs)            state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt_idx   <= '0;
            cap_we    <= 1'b0;
            cap_id    <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_wstrb <= '0;
            cap_rdata <= '0;
            cap_resp  <= RESP_OKAY;
        end else begin
            state <= state_nx;
            if (accept) begin
                gnt_idx   <= sel_idx;
                cap_we    <= sel_we;
                cap_id    <= sel_we ? s_awid[sel_idx]   : s_arid[sel_idx];
                cap_addr  <= sel_we ? s_awaddr[sel_idx] : s_araddr[sel_idx];
                cap_wdata <= sel_we ? s_wdata[sel_idx]  : '0;
                cap_wstrb <= sel_we ? s_wstrb[sel_idx]  : '0;
            end
            // Ack is only honoured in BUS; a late ack after timeout is dropped.
            if (state == BUS) begin
                if (reg_ack) begin
                    cap_rdata <= reg_rdata;
                    cap_resp  <= RESP_OKAY;
                end else if (tmo_hit) begin
                    cap_rdata <= '0;
                    cap_resp  <= RESP_SLVERR;
                end
            end
            if (resp_hs)
                rr_ptr <= (gnt_idx == PTR_W'(NPORT - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign reg_req   = (state == BUS);
    assign reg_we    = cap_we;
    assign reg_addr  = cap_addr;
    assign reg_wdata = cap_wdata;
    assign reg_wstrb = cap_wstrb;

    // Response payload is shared; only the granted port sees valid.
    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic sel;
        assign sel         = (gnt_idx == PTR_W'(p));
        assign s_bvalid[p] = (state == RESP) &&  cap_we && sel;
        assign s_rvalid[p] = (state == RESP) && !cap_we && sel;
        assign s_bid[p]    = cap_id;
        assign s_rid[p]    = cap_id;
        assign s_bresp[p]  = cap_resp;
        assign s_rresp[p]  = cap_resp;
        assign s_rdata[p]  = cap_rdata;
    end

endmodule
